// File: rtl/cpc_scandoubler_pkg.sv
// Shared video constants, level encodings and pixel bundle
// for the CPC 15 kHz to 31 kHz scandoubler.
package cpc_scandoubler_pkg;

  localparam int LINE_LEN = 512;
  localparam int H_ACTIVE = 416;
  localparam int HS_START = 424;
  localparam int HS_LEN   = 60;

  localparam int XW = $clog2(LINE_LEN);
  localparam int AW = XW + 1;

  typedef logic [XW-1:0] xpos_t;

  localparam xpos_t X_LAST = xpos_t'(LINE_LEN - 1);
  localparam xpos_t X_HACT = xpos_t'(H_ACTIVE);
  localparam xpos_t X_HS0  = xpos_t'(HS_START);
  localparam xpos_t X_HS1  = xpos_t'(HS_START + HS_LEN);

  typedef enum logic [1:0] {
    LVL_OFF  = 2'b00,
    LVL_HALF = 2'b01,
    LVL_FULL = 2'b11
  } lvl_e;

  typedef struct packed {
    lvl_e r;
    lvl_e g;
    lvl_e b;
  } pix_t;

  // An undriven GA pin floats to the resistor-divider midpoint.
  function automatic lvl_e lvl_decode(
    input logic pin,
    input logic oe
  );
    if (!oe) return LVL_HALF;
    return pin ? LVL_FULL : LVL_OFF;
  endfunction

endpackage

// File: rtl/cpc_scandoubler_linebuf.sv
// Ping-pong line store: simple dual-port RAM,
// two banks of LINE_LEN 6-bit pixels, registered read.
module cpc_linebuf
  import cpc_scandoubler_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [5:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [5:0]    rdata
);

  logic [5:0] mem [2*LINE_LEN];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cpc_scandoubler.sv
// Scandoubler: captures each GA line at 8 MHz and replays
// the previous line twice at 16 MHz with regenerated syncs.
module cpc_scandoubler
  import cpc_scandoubler_pkg::*;
(
  input  logic       ck16,
  input  logic       reset_n,
  input  logic       red,
  input  logic       red_oe,
  input  logic       green,
  input  logic       green_oe,
  input  logic       blue,
  input  logic       blue_oe,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [1:0] r_out,
  output logic [1:0] g_out,
  output logic [1:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out
);

  logic  hs_q;
  logic  hs_rise;
  logic  wr_bank_q, wr_bank_d;
  logic  wr_phase_q, wr_phase_d;
  logic  vs_q, vs_d;
  xpos_t wr_x_q, wr_x_d;
  xpos_t rd_x_q, rd_x_d;
  logic  we;
  pix_t  wpix;
  logic [5:0] rdata;

  logic  blank1_q, hs1_q, vs1_q;
  pix_t  rgb_q, rgb_d;

  assign hs_rise = hsync_in & ~hs_q;

  assign wpix.r = lvl_decode(red, red_oe);
  assign wpix.g = lvl_decode(green, green_oe);
  assign wpix.b = lvl_decode(blue, blue_oe);

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_phase_d = ~wr_phase_q;
    wr_x_d     = wr_x_q;
    vs_d       = vs_q;
    we         = 1'b0;
    rd_x_d     = (rd_x_q == X_LAST) ? '0 : rd_x_q + xpos_t'(1);
    // A new input line restarts both sides, even on a read wrap.
    if (hs_rise) begin
      wr_bank_d  = ~wr_bank_q;
      wr_phase_d = 1'b0;
      wr_x_d     = '0;
      rd_x_d     = '0;
      vs_d       = vsync_in;
    end else if (wr_phase_q && (wr_x_q != X_LAST)) begin
      we     = 1'b1;
      wr_x_d = wr_x_q + xpos_t'(1);
    end
  end

  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      hs_q       <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_phase_q <= 1'b0;
      wr_x_q     <= '0;
      rd_x_q     <= '0;
      vs_q       <= 1'b0;
    end else begin
      hs_q       <= hsync_in;
      wr_bank_q  <= wr_bank_d;
      wr_phase_q <= wr_phase_d;
      wr_x_q     <= wr_x_d;
      rd_x_q     <= rd_x_d;
      vs_q       <= vs_d;
    end
  end

  cpc_linebuf u_linebuf (
    .clk   (ck16),
    .we    (we),
    .waddr ({wr_bank_q, wr_x_q}),
    .wdata (wpix),
    .raddr ({~wr_bank_q, rd_x_q}),
    .rdata (rdata)
  );

  assign rgb_d = blank1_q ? '0 : pix_t'(rdata);

  always_ff @(posedge ck16 or negedge reset_n) begin
    if (!reset_n) begin
      blank1_q  <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      rgb_q     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      blank1_q  <= (rd_x_q >= X_HACT);
      hs1_q     <= (rd_x_q >= X_HS0) && (rd_x_q < X_HS1);
      vs1_q     <= vs_q;
      rgb_q     <= rgb_d;
      hsync_out <= hs1_q;
      vsync_out <= vs1_q;
    end
  end

  assign r_out = rgb_q.r;
  assign g_out = rgb_q.g;
  assign b_out = rgb_q.b;

endmodule

// File: tb/tb_cpc_scandoubler.sv
// Randomised bench for cpc_scandoubler against a
// timestamp-based line-doubling reference model.
`timescale 1ns/1ps
module tb_cpc_scandoubler;

  logic       ck16 = 1'b0;
  logic       reset_n = 1'b0;
  logic       red = 0, red_oe = 0;
  logic       green = 0, green_oe = 0;
  logic       blue = 0, blue_oe = 0;
  logic       hsync_in = 0, vsync_in = 0;
  logic [1:0] r_out, g_out, b_out;
  logic       hsync_out, vsync_out;

  int errs = 0;
  int checks = 0;

  always #31.25 ck16 = ~ck16;

  cpc_scandoubler u_dut (
    .ck16      (ck16),
    .reset_n   (reset_n),
    .red       (red),
    .red_oe    (red_oe),
    .green     (green),
    .green_oe  (green_oe),
    .blue      (blue),
    .blue_oe   (blue_oe),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .r_out     (r_out),
    .g_out     (g_out),
    .b_out     (b_out),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s t=%0t got=%0d want=%0d", tag, $time, obs, exp);
    end
  endtask

  function automatic bit [1:0] lvl(input bit pin, input bit oe);
    if (!oe) return 2'd1;
    return pin ? 2'd3 : 2'd0;
  endfunction

  // Reference model: edge counter, last restart edge, stored lines.
  int n = 0;
  int restart = 0;
  bit mbank = 0;
  bit hprev = 0;
  bit vsm = 0;
  bit in_rst = 1;
  bit [5:0] mem [2][512];
  bit mval [2][512];
  int rdx, e;
  bit rise;
  bit [5:0] s1_pix = 0, o_pix = 0;
  bit s1_pv = 1, s1_hs = 0, s1_vs = 0;
  bit o_pv = 1, o_hs = 0, o_vs = 0;
  bit chk_en = 0;

  always @(posedge ck16) begin
    n++;
    if (!reset_n) begin
      in_rst = 1; mbank = 0; hprev = 0; vsm = 0;
      s1_pix = 0; s1_pv = 1; s1_hs = 0; s1_vs = 0;
      o_pix = 0; o_pv = 1; o_hs = 0; o_vs = 0;
    end else begin
      if (in_rst) begin
        in_rst = 0;
        restart = n - 1;
      end
      rdx = (n - 1 - restart) % 512;
      o_pix = s1_pix; o_pv = s1_pv; o_hs = s1_hs; o_vs = s1_vs;
      if (rdx < 416) begin
        s1_pix = mem[!mbank][rdx];
        s1_pv = mval[!mbank][rdx];
      end else begin
        s1_pix = 0;
        s1_pv = 1;
      end
      s1_hs = (rdx >= 424) && (rdx < 484);
      s1_vs = vsm;
      rise = hsync_in && !hprev;
      hprev = hsync_in;
      if (rise) begin
        mbank = !mbank;
        restart = n;
        vsm = vsync_in;
      end else begin
        e = n - restart;
        if (e >= 2 && e % 2 == 0 && (e - 2) / 2 <= 510) begin
          mem[mbank][(e-2)/2] = {lvl(red, red_oe), lvl(green, green_oe),
                                 lvl(blue, blue_oe)};
          mval[mbank][(e-2)/2] = 1;
        end
      end
    end
  end

  always @(negedge ck16) begin
    if (chk_en) begin
      check("hsync", int'(hsync_out), int'(o_hs));
      check("vsync", int'(vsync_out), int'(o_vs));
      if (o_pv) check("pix", int'({r_out, g_out, b_out}), int'(o_pix));
    end
  end

  task automatic drive_pins(input int mode);
    int k;
    bit [5:0] kv;
    bit [1:0] f;
    {red, red_oe, green, green_oe, blue, blue_oe} = 6'($urandom);
    unique case (mode)
      1: begin
        k = (n + 1 - restart - 2) / 2;
        if (k < 0) k = 0;
        kv = 6'(k);
        f = kv[5:4];
        red_oe = (f != 1); red = f[1];
        f = kv[3:2];
        green_oe = (f != 1); green = f[1];
        f = kv[1:0];
        blue_oe = (f != 1); blue = f[1];
      end
      2: red_oe = 1'b0;
      3: red_oe = 1'b1;
      default: ;
    endcase
  endtask

  task automatic run_line(input int len, input int hs_w, input int mode,
                          input bit vs, input int rst_at);
    for (int c = 0; c < len; c++) begin
      @(negedge ck16);
      #1;
      if (c == rst_at) begin
        reset_n = 1'b0;
        #1;
        check("rst_mid_out",
              int'({r_out, g_out, b_out, hsync_out, vsync_out}), 0);
      end else if (!reset_n) begin
        reset_n = 1'b1;
      end
      hsync_in = (c < hs_w);
      vsync_in = vs;
      drive_pins(mode);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    chk_en = 1'b1;
    repeat (4) begin
      @(negedge ck16);
      #1;
      {red, red_oe, green, green_oe, blue, blue_oe} = 6'($urandom);
      {hsync_in, vsync_in} = 2'($urandom);
    end
    check("rst_out", int'({r_out, g_out, b_out, hsync_out, vsync_out}), 0);
    @(negedge ck16);
    #1;
    hsync_in = 1'b0;
    reset_n = 1'b1;
    #1;
    check("rst_rdx", int'(u_dut.rd_x_q), 0);
    check("rst_wrx", int'(u_dut.wr_x_q), 0);

    run_line(700, 0, 0, 0, -1);
    for (int i = 0; i < 3; i++)
      run_line(1024, 4 + $urandom_range(0, 90), 0, 0, -1);
    for (int i = 0; i < 2; i++)
      run_line(1024, 64, 1, i == 1, -1);
    run_line(1024, 64, 2, 1, -1);
    run_line(1024, 64, 3, 0, -1);
    run_line(1024, 64, 1, 0, -1);
    run_line(1000 + $urandom_range(0, 100), 30, 0, 0, -1);

    run_line(3000, 50, 0, 0, -1);
    check("wrx_sat", int'(u_dut.wr_x_q), 511);
    for (int i = 0; i < 3; i++)
      run_line(1024, 64, 1, i == 0, -1);

    run_line(1024, 64, 1, 0, 201);
    for (int i = 0; i < 4; i++)
      run_line(1024, 64, 1, 0, -1);
    repeat (4) @(negedge ck16);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
